// File: rtl/sprite_layer.sv
// sprite_layer: renders one 16x16 monochrome sprite over a flat background.
// A bitmap row is fetched from an external synchronous ROM during each line's
// horizontal blanking. New positions are held in a one-entry pending slot and
// committed at the start of vertical blanking, so a frame never mixes positions.
module sprite_layer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned INIT_X   = 312,
    parameter int unsigned INIT_Y   = 232,
    parameter logic [7:0]  FG_COLOR = 8'hE0,
    parameter logic [7:0]  BG_COLOR = 8'h03
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic [7:0]  color_data,
    output logic        rom_en,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y
);

    localparam int unsigned CW      = 10;
    localparam int unsigned SPR_DIM = 16;

    localparam logic [CW-1:0] H_END   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_END   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] SPR_LIM = CW'(SPR_DIM);
    localparam logic [CW-1:0] X_RST   = CW'(INIT_X);
    localparam logic [CW-1:0] Y_RST   = CW'(INIT_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_CAP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] act_x_q;
    logic [CW-1:0] act_y_q;
    logic [CW-1:0] pend_x_q;
    logic [CW-1:0] pend_y_q;
    logic          ready_q;
    logic [15:0]   line_buf_q;
    logic          line_hit_q;
    logic          at_h_end_q;
    logic          rom_en_q;
    logic [3:0]    rom_addr_q;
    logic [7:0]    color_q;
    logic [7:0]    color_d;

    logic          at_h_end_c;
    logic          fetch_start_c;
    logic [CW-1:0] y_next_c;
    logic [CW-1:0] dy_c;
    logic          row_hit_c;
    logic          commit_c;
    logic          take_c;
    logic          in_active_c;
    logic [CW-1:0] dx_c;
    logic          x_cov_c;
    logic [3:0]    bit_idx_c;
    logic          covered_c;

    assign color_data = color_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;
    assign pos_ready  = ready_q;

    // Line-fetch decode: one fetch per line on the first cycle at H_ACTIVE
    always_comb begin
        at_h_end_c    = (pixel_x == H_END);
        fetch_start_c = at_h_end_c && !at_h_end_q;
        y_next_c      = (pixel_y == V_LAST) ? '0 : pixel_y + CW'(1);
        dy_c          = '0;
        row_hit_c     = 1'b0;
        if (y_next_c >= act_y_q) begin
            dy_c      = y_next_c - act_y_q;
            row_hit_c = (dy_c < SPR_LIM) && (y_next_c < V_END);
        end
    end

    // Position handshake decode: commit at the first blanking line
    always_comb begin
        commit_c = (pixel_x == '0) && (pixel_y == V_END) && !ready_q;
        take_c   = pos_valid && ready_q;
    end

    // Pixel colour decode; subtraction only used when it cannot wrap
    always_comb begin
        in_active_c = (pixel_x < H_END) && (pixel_y < V_END);
        dx_c        = '0;
        x_cov_c     = 1'b0;
        if (pixel_x >= act_x_q) begin
            dx_c    = pixel_x - act_x_q;
            x_cov_c = (dx_c < SPR_LIM);
        end
        bit_idx_c = 4'(4'd15 - dx_c[3:0]);
        covered_c = line_hit_q && x_cov_c && line_buf_q[bit_idx_c];
        color_d   = BG_COLOR;
        if (!in_active_c) begin
            color_d = 8'h00;
        end else if (covered_c) begin
            color_d = FG_COLOR;
        end
    end

    // Pending slot and active position registers
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            act_x_q  <= X_RST;
            act_y_q  <= Y_RST;
            pend_x_q <= '0;
            pend_y_q <= '0;
            ready_q  <= 1'b1;
        end else if (commit_c) begin
            act_x_q <= pend_x_q;
            act_y_q <= pend_y_q;
            ready_q <= 1'b1;
        end else if (take_c) begin
            pend_x_q <= pos_x;
            pend_y_q <= pos_y;
            ready_q  <= 1'b0;
        end
    end

    // Row fetch FSM: check the next line, pulse the ROM, capture the row
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            at_h_end_q <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            line_buf_q <= '0;
            line_hit_q <= 1'b0;
        end else begin
            at_h_end_q <= at_h_end_c;
            case (state_q)
                S_IDLE: begin
                    if (fetch_start_c) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (row_hit_c) begin
                        rom_addr_q <= dy_c[3:0];
                        rom_en_q   <= 1'b1;
                        state_q    <= S_REQ;
                    end else begin
                        line_buf_q <= '0;
                        line_hit_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    rom_en_q <= 1'b0;
                    state_q  <= S_CAP;
                end
                S_CAP: begin
                    line_buf_q <= rom_data;
                    line_hit_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    rom_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // Registered colour output stage
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            color_q <= 8'h00;
        end else begin
            color_q <= color_d;
        end
    end

endmodule
